snake_dir_ctrl: RTL and testbench

Direction controller that sequences the 4:1 direction select mux of the snake game. It conditions the four raw direction buttons (synchronise, debounce, edge-detect) and arbitrates simultaneous presses. It rejects 180° reversals, buffers up to two pending turns, and commits one turn per game-step tick onto `sel_direction`, which drives the direction mux select directly.

---
 rtl/snake_pkg.sv | 11 +
 rtl/snake_dir_ctrl_btn_debounce.sv | 40 ++++
 rtl/snake_dir_ctrl.sv | 81 ++++++++
 tb/tb_snake_dir_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: direction codes, reversal helper and controller state encoding
package snake_pkg;
   localparam logic [1:0] DIR_LEFT  = 2'b00;
   localparam logic [1:0] DIR_UP    = 2'b01;
   localparam logic [1:0] DIR_RIGHT = 2'b10;
   localparam logic [1:0] DIR_DOWN  = 2'b11;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;
   function automatic logic [1:0] dir_opposite(input logic [1:0] d);
      return d ^ 2'b10;
   endfunction
endpackage

// File: rtl/snake_dir_ctrl_btn_debounce.sv
// btn_debounce: synchronise, debounce and rising-edge detect one raw button
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic          sync1_q, sync2_q, level_q, level_d, prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          diff, done;
   // count stable mismatching cycles; flip the level once the count completes
   always_comb begin
      diff    = sync2_q != level_q;
      done    = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
      cnt_d   = (!diff || done) ? '0 : cnt_q + CW'(1);
      level_d = (diff && done) ? ~level_q : level_q;
   end
   // synchroniser, counter, debounced level and its delayed copy
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         prev_q  <= level_q;
      end
   end
   assign level = level_q;
   assign press = level_q & ~prev_q;
endmodule

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: conditions buttons, filters turns, queues two and commits one per tick
module snake_dir_ctrl
   import snake_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int QDEPTH          = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_left,
   input  logic       btn_up,
   input  logic       btn_right,
   input  logic       btn_down,
   input  logic       en,
   input  logic       tick,
   output logic [1:0] sel_direction,
   output logic       dir_changed,
   output logic       pending,
   output logic       overflow
);
   localparam logic [1:0] QMAX = 2'(QDEPTH);
   logic [3:0] press, levels_unused;
   state_t     state_q, state_d;
   logic [1:0] sel_q, sel_d, count_q, count_d, req, ref_dir;
   logic [1:0] q_q [2];
   logic [1:0] q_d [2];
   logic       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic       dir_changed_q, dir_changed_d, pending_q, pending_d, overflow_q, overflow_d;
   logic       active, accept, push, pop;
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left  (.clk(clk), .rst(rst), .btn_raw(btn_left),  .level(levels_unused[DIR_LEFT]),  .press(press[DIR_LEFT]));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up    (.clk(clk), .rst(rst), .btn_raw(btn_up),    .level(levels_unused[DIR_UP]),    .press(press[DIR_UP]));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (.clk(clk), .rst(rst), .btn_raw(btn_right), .level(levels_unused[DIR_RIGHT]), .press(press[DIR_RIGHT]));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down  (.clk(clk), .rst(rst), .btn_raw(btn_down),  .level(levels_unused[DIR_DOWN]),  .press(press[DIR_DOWN]));
   // FSM next state, arbitration, reversal filter and queue update
   always_comb begin
      state_d       = (state_q == ST_IDLE) ? (en ? ST_RUN : ST_IDLE) : (en ? ST_RUN : ST_PAUSE);
      active        = en & (state_q != ST_IDLE);
      req           = press[DIR_UP] ? DIR_UP : press[DIR_DOWN] ? DIR_DOWN : press[DIR_LEFT] ? DIR_LEFT : DIR_RIGHT;
      ref_dir       = (count_q != 2'd0) ? q_q[~wr_ptr_q] : sel_q;
      accept        = active & (|press) & (req != ref_dir) & (req != dir_opposite(ref_dir));
      push          = accept & (count_q != QMAX);
      pop           = tick & active & (count_q != 2'd0);
      q_d           = q_q;
      q_d[wr_ptr_q] = push ? req : q_q[wr_ptr_q];
      wr_ptr_d      = wr_ptr_q ^ push;
      rd_ptr_d      = rd_ptr_q ^ pop;
      count_d       = count_q + {1'b0, push} - {1'b0, pop};
      sel_d         = pop ? q_q[rd_ptr_q] : sel_q;
      dir_changed_d = pop;
      overflow_d    = accept & ~push;
      pending_d     = count_d != 2'd0;
   end
   // controller state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         sel_q         <= DIR_RIGHT;
         count_q       <= 2'd0;
         q_q           <= '{2'b00, 2'b00};
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
         dir_changed_q <= 1'b0;
         pending_q     <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         count_q       <= count_d;
         q_q           <= q_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         dir_changed_q <= dir_changed_d;
         pending_q     <= pending_d;
         overflow_q    <= overflow_d;
      end
   end
   assign sel_direction = sel_q;
   assign dir_changed   = dir_changed_q;
   assign pending       = pending_q;
   assign overflow      = overflow_q;
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: directed scenario checks of the snake direction controller
module tb_snake_dir_ctrl;
   logic       clk = 1'b0;
   logic       rst, bl, bu, br, bd, en, tick;
   logic [1:0] sel;
   logic       dir_changed, pending, overflow;
   int         n_tests = 0, n_fail = 0, ovf_seen = 0, chg_seen = 0;

   snake_dir_ctrl #(.DEBOUNCE_CYCLES(4), .QDEPTH(2)) dut (
      .clk(clk), .rst(rst), .btn_left(bl), .btn_up(bu), .btn_right(br), .btn_down(bd),
      .en(en), .tick(tick), .sel_direction(sel), .dir_changed(dir_changed),
      .pending(pending), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      if (overflow) ovf_seen++;
      if (dir_changed) chg_seen++;
   endtask

   // b[0]=left b[1]=up b[2]=right b[3]=down
   task automatic set_btn(input logic [3:0] b);
      {bd, br, bu, bl} = b;
   endtask

   task automatic press(input logic [3:0] b);
      set_btn(b);
      repeat (10) step();
      set_btn(4'b0000);
      repeat (10) step();
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; tick = 1'b0;
      set_btn(4'b0000);
      repeat (2) step();
      rst = 1'b0;
      ovf_seen = 0; chg_seen = 0;
   endtask

   task automatic start();
      en = 1'b1;
      repeat (2) step();
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (sel !== 2'b10) begin n_fail++; $display("FAIL reset_sel: got %b want 10", sel); end
      n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", pending); end
      n_tests++; if (dir_changed !== 1'b0) begin n_fail++; $display("FAIL reset_dir_changed: got %b want 0", dir_changed); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
   endtask

   task automatic test_single_turn();
      do_reset(); start();
      press(4'b0010);
      n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL single_pending: got %b want 1", pending); end
      n_tests++; if (sel !== 2'b10) begin n_fail++; $display("FAIL single_sel_before: got %b want 10", sel); end
      chg_seen = 0;
      do_tick();
      n_tests++; if (sel !== 2'b01) begin n_fail++; $display("FAIL single_sel_after: got %b want 01", sel); end
      n_tests++; if (dir_changed !== 1'b1) begin n_fail++; $display("FAIL single_changed: got %b want 1", dir_changed); end
      step();
      n_tests++; if (chg_seen !== 1) begin n_fail++; $display("FAIL single_changed_width: got %0d want 1", chg_seen); end
      n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL single_pending_after: got %b want 0", pending); end
   endtask

   task automatic test_reject();
      do_reset(); start();
      press(4'b0001);
      n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reject_reversal: pending %b want 0", pending); end
      press(4'b0100);
      n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reject_duplicate: pending %b want 0", pending); end
      do_tick(); step();
      n_tests++; if (sel !== 2'b10) begin n_fail++; $display("FAIL reject_sel: got %b want 10", sel); end
      n_tests++; if (chg_seen !== 0) begin n_fail++; $display("FAIL reject_changed: got %0d pulses want 0", chg_seen); end
   endtask

   task automatic test_overflow();
      do_reset(); start();
      press(4'b0010);
      press(4'b0001);
      n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL ovf_pending: got %b want 1", pending); end
      press(4'b0100);
      n_tests++; if (ovf_seen !== 0) begin n_fail++; $display("FAIL ovf_reversal_silent: got %0d pulses want 0", ovf_seen); end
      press(4'b0010);
      n_tests++; if (ovf_seen !== 1) begin n_fail++; $display("FAIL ovf_pulse: got %0d pulses want 1", ovf_seen); end
      do_tick();
      n_tests++; if (sel !== 2'b01) begin n_fail++; $display("FAIL ovf_first_commit: got %b want 01", sel); end
      n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL ovf_pending_mid: got %b want 1", pending); end
      step();
      do_tick();
      n_tests++; if (sel !== 2'b00) begin n_fail++; $display("FAIL ovf_second_commit: got %b want 00", sel); end
      n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL ovf_pending_end: got %b want 0", pending); end
   endtask

   task automatic test_simultaneous();
      do_reset(); start();
      press(4'b0011);
      n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL simul_pending: got %b want 1", pending); end
      do_tick();
      n_tests++; if (sel !== 2'b01) begin n_fail++; $display("FAIL simul_winner: got %b want 01", sel); end
      n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL simul_loser_dropped: pending %b want 0", pending); end
   endtask

   task automatic test_pause();
      do_reset(); start();
      en = 1'b0; step();
      press(4'b1000);
      n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL pause_press: pending %b want 0", pending); end
      do_tick(); step();
      n_tests++; if (sel !== 2'b10) begin n_fail++; $display("FAIL pause_tick_sel: got %b want 10", sel); end
      n_tests++; if (chg_seen !== 0) begin n_fail++; $display("FAIL pause_tick_changed: got %0d want 0", chg_seen); end
      en = 1'b1; repeat (2) step();
      set_btn(4'b1000);
      repeat (6) step();
      do_tick();
      n_tests++; if (sel !== 2'b10) begin n_fail++; $display("FAIL nobypass_sel: got %b want 10", sel); end
      n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL nobypass_pending: got %b want 1", pending); end
      set_btn(4'b0000);
      repeat (10) step();
      do_tick();
      n_tests++; if (sel !== 2'b11) begin n_fail++; $display("FAIL nobypass_commit: got %b want 11", sel); end
      step();
      press(4'b0001);
      en = 1'b0; step();
      do_tick(); step();
      n_tests++; if (pending !== 1'b1 || sel !== 2'b11) begin n_fail++; $display("FAIL pause_retain: pending %b sel %b want 1 11", pending, sel); end
      en = 1'b1; step();
      do_tick();
      n_tests++; if (sel !== 2'b00) begin n_fail++; $display("FAIL pause_resume_commit: got %b want 00", sel); end
   endtask

   task automatic test_reset_mid();
      do_reset(); start();
      press(4'b0010);
      press(4'b0001);
      n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL rstmid_full: pending %b want 1", pending); end
      set_btn(4'b1000);
      repeat (5) step();
      rst = 1'b1;
      set_btn(4'b0000);
      step();
      rst = 1'b0;
      n_tests++; if (sel !== 2'b10) begin n_fail++; $display("FAIL rstmid_sel: got %b want 10", sel); end
      n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL rstmid_pending: got %b want 0", pending); end
      repeat (12) step();
      n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_strobe: pending %b want 0", pending); end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; tick = 1'b0;
      set_btn(4'b0000);
      test_reset();
      test_single_turn();
      test_reject();
      test_overflow();
      test_simultaneous();
      test_pause();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
